// File: rtl/cv_seq_pkg.sv
// Shared sequence definitions for the sequence generator and the tracker:
// the 16-entry sequence ROM, its inverse lookup, index stepping and the
// tracker state encoding.
package cv_seq_pkg;

    typedef logic [3:0] nib_t;

    // Fixed sequence, index 0 first. Every nibble value appears exactly once.
    localparam nib_t SEQ_ROM [16] = '{
        4'h3, 4'hA, 4'h6, 4'hF, 4'h1, 4'hC, 4'h8, 4'h5,
        4'hE, 4'h0, 4'hB, 4'h7, 4'h2, 4'hD, 4'h9, 4'h4
    };

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCK   = 2'd2
    } seq_state_t;

    // Index holding value v; unique because the ROM is a permutation.
    function automatic nib_t seq_inv(input nib_t v);
        nib_t idx;
        idx = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (SEQ_ROM[i] == v) begin
                idx = nib_t'(i);
            end
        end
        return idx;
    endfunction

    // Neighbouring index in the given direction; 4-bit arithmetic wraps mod 16.
    function automatic nib_t seq_step(input nib_t idx, input logic up);
        return up ? nib_t'(idx + 4'd1) : nib_t'(idx - 4'd1);
    endfunction

endpackage

// File: rtl/seq_tracker_if.sv
// Sample/status bundle between a sample source (master) and the
// sequence tracker (slave).
interface seq_tracker_if
    import cv_seq_pkg::*;
#(
    parameter int unsigned ERR_W = 8
);

    logic             STROBE;
    nib_t             SEQ_I;
    logic             UP;
    logic             CLR;
    nib_t             NOM;
    nib_t             SEQ_EXP;
    logic             LOCKED;
    logic             ERR;
    logic [ERR_W-1:0] ERR_CNT;

    modport master (
        output STROBE, SEQ_I, UP, CLR,
        input  NOM, SEQ_EXP, LOCKED, ERR, ERR_CNT
    );

    modport slave (
        input  STROBE, SEQ_I, UP, CLR,
        output NOM, SEQ_EXP, LOCKED, ERR, ERR_CNT
    );

endinterface

// File: rtl/cv_sat_cnt.sv
// Saturating up-counter with synchronous clear. A clear coinciding with an
// increment leaves the count at one so that event is not lost.
module cv_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         INC,
    input  logic         CLR,
    output logic [W-1:0] cnt
);

    // Count increments, holding at all-ones; clear has priority over holding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (CLR) begin
            cnt <= INC ? W'(1) : '0;
        end else if (INC && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_tracker.sv
// Sequence tracker: locks onto the position of incoming 4-bit samples in the
// fixed 16-entry sequence, flywheels the index once locked and counts
// mismatches. NOM/LOCKED/ERR are registered; SEQ_EXP follows NOM and live UP.
module seq_tracker
    import cv_seq_pkg::*;
#(
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned MISS_MAX = 2
) (
    input logic          CLK_48,
    input logic          SYS_NRST,
    seq_tracker_if.slave bus
);

    localparam int unsigned MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);
    // Miss count that, with one more mismatch, reaches MISS_MAX and drops lock.
    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    seq_state_t        state;
    nib_t              nom;
    logic              locked;
    logic              err;
    logic [MISS_W-1:0] miss;

    nib_t nxt;
    nib_t exp_val;
    logic hit;
    logic err_inc;

    // Next index, expected value and the mismatch-increment qualifier.
    always_comb begin
        nxt     = seq_step(nom, bus.UP);
        exp_val = SEQ_ROM[nxt];
        hit     = (bus.SEQ_I == exp_val);
        err_inc = bus.STROBE && (state == LOCK) && !hit;
    end

    // Hunt/verify/lock FSM with its index datapath; only strobes move it.
    always_ff @(posedge CLK_48 or negedge SYS_NRST) begin
        if (!SYS_NRST) begin
            state  <= HUNT;
            nom    <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
            miss   <= '0;
        end else begin
            err <= 1'b0;
            if (bus.STROBE) begin
                case (state)
                    HUNT: begin
                        nom   <= seq_inv(bus.SEQ_I);
                        state <= VERIFY;
                    end
                    VERIFY: begin
                        if (hit) begin
                            nom    <= nxt;
                            state  <= LOCK;
                            locked <= 1'b1;
                            miss   <= '0;
                        end else begin
                            nom <= seq_inv(bus.SEQ_I);
                        end
                    end
                    LOCK: begin
                        if (hit) begin
                            nom  <= nxt;
                            miss <= '0;
                        end else begin
                            err <= 1'b1;
                            if (miss == MISS_LAST) begin
                                // Lock lost: index is frozen at its last value.
                                state  <= HUNT;
                                locked <= 1'b0;
                                miss   <= '0;
                            end else begin
                                nom  <= nxt;
                                miss <= miss + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        miss   <= '0;
                    end
                endcase
            end
        end
    end

    cv_sat_cnt #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk  (CLK_48),
        .rst_n(SYS_NRST),
        .INC  (err_inc),
        .CLR  (bus.CLR),
        .cnt  (bus.ERR_CNT)
    );

    assign bus.NOM     = nom;
    assign bus.SEQ_EXP = exp_val;
    assign bus.LOCKED  = locked;
    assign bus.ERR     = err;

endmodule
